writeback_stage: RTL and testbench

//  Final (WB) pipeline stage; directly downstream of memory_access. Registers the MEM/WB bundle and waits for the

---
 rtl/writeback_stage_pkg.sv | 28 ++
 rtl/writeback_stage_load_align.sv | 39 +++
 rtl/writeback_stage.sv | 124 ++++++++++++
 tb/tb_writeback_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared types for the writeback stage: load-type codes, FSM state encodings and widths.
package writeback_stage_pkg;

  localparam int unsigned DataWidth    = 32;
  localparam int unsigned RegAddrWidth = 5;

  typedef enum logic [2:0] {
    LtLb  = 3'd0,
    LtLbu = 3'd1,
    LtLh  = 3'd2,
    LtLhu = 3'd3,
    LtLw  = 3'd4
  } load_type_e;

  typedef enum logic [2:0] {
    StEmpty   = 3'd0,
    StWait    = 3'd1,
    StReady   = 3'd2,
    StDone    = 3'd3,
    StDiscard = 3'd4
  } wb_state_e;

  // States in which a data-SRAM response is still outstanding.
  function automatic logic is_busy(input wb_state_e s);
    return (s == StWait) || (s == StDiscard);
  endfunction

endpackage

// File: rtl/writeback_stage_load_align.sv
// Combinational load alignment: picks the addressed byte/half and sign- or zero-extends it.
module writeback_stage_load_align
  import writeback_stage_pkg::*;
#(
  parameter int unsigned DW = DataWidth
) (
  input  logic [DW-1:0] rdata_i,
  input  logic [1:0]    addr_lo_i,
  input  logic [2:0]    load_type_i,
  output logic [DW-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    unique case (addr_lo_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      2'd3: byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    data_o = rdata_i;
    case (load_type_e'(load_type_i))
      LtLb:    data_o = {{(DW - 8){byte_sel[7]}}, byte_sel};
      LtLbu:   data_o = {{(DW - 8){1'b0}}, byte_sel};
      LtLh:    data_o = {{(DW - 16){half_sel[15]}}, half_sel};
      LtLhu:   data_o = {{(DW - 16){1'b0}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: holds the MEM/WB bundle, waits for load data, and retires each
// instruction with exactly one register-file write plus the matching commit trace.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int unsigned DW = DataWidth,
  parameter int unsigned RW = RegAddrWidth
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_in,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] final_result,
  input  logic [RW-1:0] write_reg_in,
  input  logic          reg_write_in,
  input  logic          mem_to_reg_in,
  input  logic [2:0]    load_type_in,
  input  logic [1:0]    addr_lo_in,
  input  logic [DW-1:0] pc_in,
  input  logic [DW-1:0] inst_in,
  input  logic [DW-1:0] data_rdata,
  input  logic          data_data_ok,
  output logic          wb_stall,
  output logic          rf_we,
  output logic [RW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic [DW-1:0] debug_wb_pc,
  output logic [3:0]    debug_wb_rf_wen,
  output logic [RW-1:0] debug_wb_rf_wnum,
  output logic [DW-1:0] debug_wb_rf_wdata
);

  wb_state_e     state_q;
  logic [DW-1:0] result_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] pc_q;
  logic [RW-1:0] waddr_q;
  logic          reg_write_q;
  logic          mem_to_reg_q;
  logic [2:0]    load_type_q;
  logic [1:0]    addr_lo_q;

  logic [DW-1:0] aligned_data;
  logic          load_en;
  logic          unused_inst;

  // The instruction word travels with the bundle but nothing in WB consumes it.
  assign unused_inst = ^inst_in;

  assign load_en = !stall_in && !is_busy(state_q);

  writeback_stage_load_align #(
    .DW(DW)
  ) u_load_align (
    .rdata_i    (data_rdata),
    .addr_lo_i  (addr_lo_q),
    .load_type_i(load_type_q),
    .data_o     (aligned_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StEmpty;
      result_q     <= '0;
      wdata_q      <= '0;
      pc_q         <= '0;
      waddr_q      <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      load_type_q  <= '0;
      addr_lo_q    <= '0;
    end else if (flush) begin
      // An outstanding response must still be swallowed unless it arrives right now.
      if (is_busy(state_q) && !data_data_ok) begin
        state_q <= StDiscard;
      end else begin
        state_q <= StEmpty;
      end
    end else begin
      unique case (state_q)
        StWait: begin
          if (data_data_ok) begin
            wdata_q <= aligned_data;
            state_q <= StReady;
          end
        end
        StDiscard: begin
          if (data_data_ok) begin
            state_q <= StEmpty;
          end
        end
        default: begin
          if (load_en) begin
            if (in_valid) begin
              result_q     <= final_result;
              pc_q         <= pc_in;
              waddr_q      <= write_reg_in;
              reg_write_q  <= reg_write_in;
              mem_to_reg_q <= mem_to_reg_in;
              load_type_q  <= load_type_in;
              addr_lo_q    <= addr_lo_in;
              state_q      <= mem_to_reg_in ? StWait : StReady;
            end else begin
              state_q <= StEmpty;
            end
          end else if (state_q == StReady) begin
            state_q <= StDone;
          end
        end
      endcase
    end
  end

  assign wb_stall          = is_busy(state_q);
  assign rf_we             = (state_q == StReady) && reg_write_q && (waddr_q != '0);
  assign rf_waddr          = waddr_q;
  assign rf_wdata          = mem_to_reg_q ? wdata_q : result_q;
  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: stimulus pushes expected commits, a monitor checks them.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        flush;
  logic        in_valid;
  logic [31:0] final_result;
  logic [4:0]  write_reg_in;
  logic        reg_write_in;
  logic        mem_to_reg_in;
  logic [2:0]  load_type_in;
  logic [1:0]  addr_lo_in;
  logic [31:0] pc_in;
  logic [31:0] inst_in;
  logic [31:0] data_rdata;
  logic        data_data_ok;
  logic        wb_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk              (clk),
    .rst              (rst),
    .stall_in         (stall_in),
    .flush            (flush),
    .in_valid         (in_valid),
    .final_result     (final_result),
    .write_reg_in     (write_reg_in),
    .reg_write_in     (reg_write_in),
    .mem_to_reg_in    (mem_to_reg_in),
    .load_type_in     (load_type_in),
    .addr_lo_in       (addr_lo_in),
    .pc_in            (pc_in),
    .inst_in          (inst_in),
    .data_rdata       (data_rdata),
    .data_data_ok     (data_data_ok),
    .wb_stall         (wb_stall),
    .rf_we            (rf_we),
    .rf_waddr         (rf_waddr),
    .rf_wdata         (rf_wdata),
    .debug_wb_pc      (debug_wb_pc),
    .debug_wb_rf_wen  (debug_wb_rf_wen),
    .debug_wb_rf_wnum (debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [4:0] waddr, input logic [31:0] wdata, input logic [31:0] pc);
    exp_t e;
    e.waddr = waddr;
    e.wdata = wdata;
    e.pc    = pc;
    exp_q.push_back(e);
  endtask

  // Monitor: every commit must match the oldest expected one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rf_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_commit: got waddr=%0d wdata=%h pc=%h required no write",
                   rf_waddr, rf_wdata, debug_wb_pc);
        end else begin
          e = exp_q.pop_front();
          chk("commit_waddr", {27'd0, rf_waddr}, {27'd0, e.waddr});
          chk("commit_wdata", rf_wdata, e.wdata);
          chk("commit_pc", debug_wb_pc, e.pc);
          chk("commit_wen", {28'd0, debug_wb_rf_wen}, 32'hF);
          chk("commit_wnum", {27'd0, debug_wb_rf_wnum}, {27'd0, e.waddr});
          chk("commit_dwdata", debug_wb_rf_wdata, e.wdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one bundle for exactly one capture edge.
  task automatic drive(input logic m2r, input logic regw, input logic [4:0] wreg,
                       input logic [31:0] res, input logic [2:0] lt, input logic [1:0] alo,
                       input logic [31:0] pc);
    in_valid      = 1'b1;
    mem_to_reg_in = m2r;
    reg_write_in  = regw;
    write_reg_in  = wreg;
    final_result  = res;
    load_type_in  = lt;
    addr_lo_in    = alo;
    pc_in         = pc;
    inst_in       = pc ^ 32'h0000_0013;
    step();
    in_valid = 1'b0;
  endtask

  // Load whose response is sampled two edges after capture.
  task automatic load_op(input string name, input logic [2:0] lt, input logic [1:0] alo,
                         input logic [31:0] rdata, input logic [4:0] wreg,
                         input logic [31:0] pc, input logic [31:0] exp_data);
    push(wreg, exp_data, pc);
    drive(1'b1, 1'b1, wreg, 32'hFFFF_FFFF, lt, alo, pc);
    @(negedge clk);
    chk({name, "_stall1"}, {31'd0, wb_stall}, 32'd1);
    chk({name, "_nowe1"}, {31'd0, rf_we}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk({name, "_stall2"}, {31'd0, wb_stall}, 32'd1);
    data_rdata   = rdata;
    data_data_ok = 1'b1;
    step();
    data_data_ok = 1'b0;
    @(negedge clk);
    chk({name, "_stall_clr"}, {31'd0, wb_stall}, 32'd0);
    chk({name, "_commit"}, {31'd0, rf_we}, 32'd1);
    step();
  endtask

  initial begin
    rst           = 1'b1;
    stall_in      = 1'b0;
    flush         = 1'b0;
    in_valid      = 1'b0;
    final_result  = '0;
    write_reg_in  = '0;
    reg_write_in  = 1'b0;
    mem_to_reg_in = 1'b0;
    load_type_in  = '0;
    addr_lo_in    = '0;
    pc_in         = '0;
    inst_in       = '0;
    data_rdata    = '0;
    data_data_ok  = 1'b0;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", {31'd0, wb_stall}, 32'd0);
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_pc", debug_wb_pc, 32'd0);
    chk("rst_wen", {28'd0, debug_wb_rf_wen}, 32'd0);
    step();

    // ALU op: commits the cycle after capture, for one cycle only.
    push(5'd5, 32'h1234_5678, 32'h0000_0100);
    drive(1'b0, 1'b1, 5'd5, 32'h1234_5678, LtLw, 2'd0, 32'h0000_0100);
    @(negedge clk);
    chk("alu_latency", {31'd0, rf_we}, 32'd1);
    step();
    @(negedge clk);
    chk("alu_one_pulse", {31'd0, rf_we}, 32'd0);
    step();

    load_op("lb3", LtLb, 2'd3, 32'h80FF_0000, 5'd6, 32'h0000_0104, 32'hFFFF_FF80);
    load_op("lhu2", LtLhu, 2'd2, 32'hBEEF_0001, 5'd7, 32'h0000_0108, 32'h0000_BEEF);
    load_op("lw", LtLw, 2'd0, 32'hDEAD_BEEF, 5'd8, 32'h0000_010C, 32'hDEAD_BEEF);
    load_op("lh0", LtLh, 2'd0, 32'h1234_8001, 5'd9, 32'h0000_0110, 32'hFFFF_8001);
    load_op("lbu1", LtLbu, 2'd1, 32'h0000_A500, 5'd10, 32'h0000_0114, 32'h0000_00A5);
    load_op("lb1pos", LtLb, 2'd1, 32'hFFFF_7FFF, 5'd11, 32'h0000_0118, 32'h0000_007F);

    // Long stall after an ALU commit: one write, pc held.
    push(5'd12, 32'hCAFE_F00D, 32'h0000_0200);
    drive(1'b0, 1'b1, 5'd12, 32'hCAFE_F00D, LtLw, 2'd0, 32'h0000_0200);
    stall_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_pc", debug_wb_pc, 32'h0000_0200);
      chk("stall_we", {31'd0, rf_we}, (i == 0) ? 32'd1 : 32'd0);
      step();
    end
    stall_in = 1'b0;
    step();

    // Write to x0 is suppressed.
    drive(1'b0, 1'b1, 5'd0, 32'h0000_0055, LtLw, 2'd0, 32'h0000_0204);
    @(negedge clk);
    chk("x0_we", {31'd0, rf_we}, 32'd0);
    step();

    // Flush in WAIT; response arrives three edges after the flush.
    drive(1'b1, 1'b1, 5'd13, 32'h0, LtLw, 2'd0, 32'h0000_0300);
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("flush_stall", {31'd0, wb_stall}, 32'd1);
      chk("flush_we", {31'd0, rf_we}, 32'd0);
      step();
    end
    @(negedge clk);
    chk("flush_stall3", {31'd0, wb_stall}, 32'd1);
    data_rdata   = 32'h1111_1111;
    data_data_ok = 1'b1;
    step();
    data_data_ok = 1'b0;
    @(negedge clk);
    chk("flush_stall_drop", {31'd0, wb_stall}, 32'd0);
    chk("flush_no_we", {31'd0, rf_we}, 32'd0);
    step();

    // Flush coinciding with data_ok goes straight to empty.
    drive(1'b1, 1'b1, 5'd14, 32'h0, LtLw, 2'd0, 32'h0000_0310);
    flush        = 1'b1;
    data_data_ok = 1'b1;
    step();
    flush        = 1'b0;
    data_data_ok = 1'b0;
    @(negedge clk);
    chk("flush_ok_stall", {31'd0, wb_stall}, 32'd0);
    chk("flush_ok_we", {31'd0, rf_we}, 32'd0);
    step();

    // Reset during WAIT, then a stray response.
    drive(1'b1, 1'b1, 5'd15, 32'h0, LtLw, 2'd0, 32'h0000_0400);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rstw_stall", {31'd0, wb_stall}, 32'd0);
    data_rdata   = 32'h7777_7777;
    data_data_ok = 1'b1;
    step();
    data_data_ok = 1'b0;
    @(negedge clk);
    chk("rstw_we", {31'd0, rf_we}, 32'd0);
    chk("rstw_stall2", {31'd0, wb_stall}, 32'd0);
    chk("rstw_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("rstw_wdata", rf_wdata, 32'd0);
    chk("rstw_pc", debug_wb_pc, 32'd0);
    chk("rstw_wen", {28'd0, debug_wb_rf_wen}, 32'd0);
    step();

    // Normal operation resumes afterwards.
    push(5'd16, 32'hA5A5_0F0F, 32'h0000_0500);
    drive(1'b0, 1'b1, 5'd16, 32'hA5A5_0F0F, LtLw, 2'd0, 32'h0000_0500);
    @(negedge clk);
    chk("post_rst_we", {31'd0, rf_we}, 32'd1);
    repeat (3) step();

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
